// File: rtl/simmem_release_scheduler.sv
// Delay-slot scheduler: holds each request for its programmed delay, then
// releases IDs in per-ID age order to the linked-list bank.
// Ports: clk_i/rst_i (sync, active-high); req_* allocate a slot (valid/ready);
// release_en_o per-ID enable; rsp_* observed bank handshake frees the
// oldest slot of that ID; occupancy_o busy-slot count; err_o sticky error.
// Optional macro SIMMEM_RELEASE_SCHEDULER_ERR_EN builds the error flag.
module simmem_release_scheduler #(
  parameter int unsigned IDWidth    = 2,
  parameter int unsigned NbSlots    = 8,
  parameter int unsigned DelayWidth = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [IDWidth-1:0]           req_id_i,
  input  logic [DelayWidth-1:0]        req_delay_i,
  output logic [2**IDWidth-1:0]        release_en_o,
  input  logic                         rsp_valid_i,
  input  logic                         rsp_ready_i,
  input  logic [IDWidth-1:0]           rsp_id_i,
  output logic [$clog2(NbSlots):0]     occupancy_o,
  output logic                         err_o
);

  localparam int unsigned SlotW = (NbSlots > 1) ? $clog2(NbSlots) : 1;
  localparam int unsigned OccW  = $clog2(NbSlots) + 1;

  typedef enum logic [1:0] {
    SlotFree     = 2'd0,
    SlotCounting = 2'd1,
    SlotExpired  = 2'd2
  } slot_st_e;

  slot_st_e               st_q  [NbSlots];
  slot_st_e               st_d  [NbSlots];
  logic [IDWidth-1:0]     id_q  [NbSlots];
  logic [IDWidth-1:0]     id_d  [NbSlots];
  logic [DelayWidth-1:0]  cnt_q [NbSlots];
  logic [DelayWidth-1:0]  cnt_d [NbSlots];
  // age_q[j][i] set: slot j was allocated before slot i
  logic [NbSlots-1:0]     age_q [NbSlots];
  logic [NbSlots-1:0]     age_d [NbSlots];

  logic [NbSlots-1:0] busy;
  logic [NbSlots-1:0] head;
  logic               alloc_ok;
  logic [SlotW-1:0]   alloc_idx;
  logic               free_hit;
  logic [SlotW-1:0]   free_idx;
  logic               req_fire;
  logic               rsp_fire;

  always_comb begin
    for (int i = 0; i < NbSlots; i++) begin
      busy[i] = (st_q[i] != SlotFree);
    end
  end

  // Descending scan so the lowest free index wins.
  always_comb begin
    alloc_ok  = 1'b0;
    alloc_idx = '0;
    for (int i = NbSlots - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        alloc_ok  = 1'b1;
        alloc_idx = SlotW'(i);
      end
    end
  end

  // A slot is head of its ID if no busy slot of the same ID is older.
  always_comb begin
    for (int i = 0; i < NbSlots; i++) begin
      head[i] = busy[i];
      for (int j = 0; j < NbSlots; j++) begin
        if (j != i && busy[j] && id_q[j] == id_q[i] && age_q[j][i]) begin
          head[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    release_en_o = '0;
    free_hit     = 1'b0;
    free_idx     = '0;
    for (int i = 0; i < NbSlots; i++) begin
      if (head[i] && st_q[i] == SlotExpired) begin
        release_en_o[id_q[i]] = 1'b1;
        if (id_q[i] == rsp_id_i) begin
          free_hit = 1'b1;
          free_idx = SlotW'(i);
        end
      end
    end
  end

  always_comb begin
    occupancy_o = '0;
    for (int i = 0; i < NbSlots; i++) begin
      occupancy_o = occupancy_o + OccW'(busy[i]);
    end
  end

  assign req_ready_o = alloc_ok;
  assign req_fire    = req_valid_i && alloc_ok;
  assign rsp_fire    = rsp_valid_i && rsp_ready_i;

  always_comb begin
    st_d  = st_q;
    id_d  = id_q;
    cnt_d = cnt_q;
    age_d = age_q;
    for (int i = 0; i < NbSlots; i++) begin
      if (st_q[i] == SlotCounting) begin
        if (cnt_q[i] <= DelayWidth'(1)) begin
          st_d[i]  = SlotExpired;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] - DelayWidth'(1);
        end
      end
    end
    // Only an expired head can leave; anything else is ignored.
    if (rsp_fire && free_hit) begin
      st_d[free_idx]  = SlotFree;
      cnt_d[free_idx] = '0;
    end
    // alloc_idx was free at cycle start, so never collides with free_idx.
    if (req_fire) begin
      st_d[alloc_idx]  = (req_delay_i == '0) ? SlotExpired : SlotCounting;
      id_d[alloc_idx]  = req_id_i;
      cnt_d[alloc_idx] = req_delay_i;
      age_d[alloc_idx] = '0;
      for (int j = 0; j < NbSlots; j++) begin
        if (SlotW'(j) != alloc_idx) begin
          age_d[j][alloc_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NbSlots; i++) begin
        st_q[i]  <= SlotFree;
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NbSlots; i++) begin
        st_q[i]  <= st_d[i];
        id_q[i]  <= id_d[i];
        cnt_q[i] <= cnt_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

`ifdef SIMMEM_RELEASE_SCHEDULER_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (rsp_fire && !free_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Bench for simmem_release_scheduler: directed scenarios plus random
// traffic against a queue-based model of outstanding requests.
module tb_simmem_release_scheduler;

  localparam int NS = 8;
`ifdef SIMMEM_RELEASE_SCHEDULER_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [1:0] req_id_i;
  logic [7:0] req_delay_i;
  logic [3:0] release_en_o;
  logic       rsp_valid_i;
  logic       rsp_ready_i;
  logic [1:0] rsp_id_i;
  logic [3:0] occupancy_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  // Outstanding requests in acceptance order; remaining delay per entry.
  int m_id[$];
  int m_rem[$];
  bit m_err;

  simmem_release_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_id_i(req_id_i), .req_delay_i(req_delay_i),
    .release_en_o(release_en_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_i(rsp_ready_i),
    .rsp_id_i(rsp_id_i), .occupancy_o(occupancy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] exp_rel();
    logic [3:0] r = '0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < m_id.size(); i++) begin
        if (m_id[i] == k) begin
          if (m_rem[i] == 0) r[k] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic model_step(input bit r, input bit rv, input int rid,
                            input int dly, input bit hs, input int sid);
    bit acc;
    int f;
    if (r) begin
      m_id.delete();
      m_rem.delete();
      m_err = 1'b0;
      return;
    end
    acc = rv && (m_id.size() < NS);
    if (hs) begin
      f = -1;
      for (int i = 0; i < m_id.size(); i++) begin
        if (m_id[i] == sid) begin
          f = i;
          break;
        end
      end
      if (f >= 0 && m_rem[f] == 0) begin
        m_id.delete(f);
        m_rem.delete(f);
      end else if (ErrEn) begin
        m_err = 1'b1;
      end
    end
    for (int i = 0; i < m_rem.size(); i++) begin
      if (m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
    end
    if (acc) begin
      m_id.push_back(rid);
      m_rem.push_back(dly);
    end
  endtask

  // Drive one cycle at the falling edge, advance model, sample after edge.
  task automatic step(input bit r, input bit rv, input logic [1:0] rid,
                      input logic [7:0] dly, input bit sv, input bit sr,
                      input logic [1:0] sid);
    rst_i       = r;
    req_valid_i = rv;
    req_id_i    = rid;
    req_delay_i = dly;
    rsp_valid_i = sv;
    rsp_ready_i = sr;
    rsp_id_i    = sid;
    model_step(r, rv, int'(rid), int'(dly), sv && sr, int'(sid));
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    step(0, 0, 2'd0, 8'd0, 0, 0, 2'd0);
  endtask

  task automatic do_reset();
    step(1, 0, 2'd0, 8'd0, 0, 0, 2'd0);
  endtask

  task automatic test_reset();
    step(1, 1, 2'd1, 8'd2, 1, 1, 2'd0);
    step(1, 1, 2'd1, 8'd2, 1, 1, 2'd0);
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b want=1", req_ready_o);
    end
    total++;
    if (release_en_o !== 4'b0) begin
      bad++; $display("FAIL rst_rel got=%b want=0000", release_en_o);
    end
    total++;
    if (occupancy_o !== 4'd0) begin
      bad++; $display("FAIL rst_occ got=%0d want=0", occupancy_o);
    end
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("FAIL rst_err got=%b want=0", err_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(0, 1, 2'd1, 8'd3, 0, 0, 2'd0);
    total++;
    if (occupancy_o !== 4'd1) begin
      bad++; $display("FAIL single_occ got=%0d want=1", occupancy_o);
    end
    idle();
    idle();
    total++;
    if (release_en_o !== 4'b0000) begin
      bad++; $display("FAIL single_early got=%b want=0000", release_en_o);
    end
    idle();
    total++;
    if (release_en_o !== 4'b0010) begin
      bad++; $display("FAIL single_rel got=%b want=0010", release_en_o);
    end
    idle();
    step(0, 0, 2'd0, 8'd0, 1, 1, 2'd1);
    total++;
    if (release_en_o !== 4'b0000 || occupancy_o !== 4'd0) begin
      bad++;
      $display("FAIL single_free got rel=%b occ=%0d want rel=0000 occ=0",
               release_en_o, occupancy_o);
    end
  endtask

  task automatic test_in_order();
    do_reset();
    step(0, 1, 2'd2, 8'd5, 0, 0, 2'd0);
    step(0, 1, 2'd2, 8'd1, 0, 0, 2'd0);
    for (int e = 2; e <= 4; e++) begin
      idle();
      total++;
      if (release_en_o[2] !== 1'b0) begin
        bad++; $display("FAIL order_hold e=%0d got=%b want=0", e, release_en_o[2]);
      end
    end
    idle();
    total++;
    if (release_en_o !== 4'b0100) begin
      bad++; $display("FAIL order_rel got=%b want=0100", release_en_o);
    end
    step(0, 0, 2'd0, 8'd0, 1, 1, 2'd2);
    total++;
    if (release_en_o !== 4'b0100 || occupancy_o !== 4'd1) begin
      bad++;
      $display("FAIL order_next got rel=%b occ=%0d want rel=0100 occ=1",
               release_en_o, occupancy_o);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < NS; i++) step(0, 1, 2'(i), 8'd20, 0, 0, 2'd0);
    total++;
    if (req_ready_o !== 1'b0 || occupancy_o !== 4'd8) begin
      bad++;
      $display("FAIL full_state got rdy=%b occ=%0d want rdy=0 occ=8",
               req_ready_o, occupancy_o);
    end
    step(0, 1, 2'd3, 8'd1, 0, 0, 2'd0);
    total++;
    if (occupancy_o !== 4'd8) begin
      bad++; $display("FAIL full_reject got=%0d want=8", occupancy_o);
    end
    for (int i = 0; i < 12; i++) idle();
    total++;
    if (release_en_o !== 4'b0001) begin
      bad++; $display("FAIL full_rel got=%b want=0001", release_en_o);
    end
    step(0, 1, 2'd2, 8'd5, 1, 1, 2'd0);
    total++;
    if (occupancy_o !== 4'd7 || req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL full_swap got occ=%0d rdy=%b want occ=7 rdy=1",
               occupancy_o, req_ready_o);
    end
    step(0, 1, 2'd2, 8'd5, 0, 0, 2'd0);
    total++;
    if (occupancy_o !== 4'd8 || req_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL full_refill got occ=%0d rdy=%b want occ=8 rdy=0",
               occupancy_o, req_ready_o);
    end
  endtask

  task automatic test_zero_delay();
    do_reset();
    step(0, 1, 2'd3, 8'd0, 0, 0, 2'd0);
    total++;
    if (release_en_o !== 4'b1000 || occupancy_o !== 4'd1) begin
      bad++;
      $display("FAIL zero_rel got rel=%b occ=%0d want rel=1000 occ=1",
               release_en_o, occupancy_o);
    end
  endtask

  task automatic test_error();
    do_reset();
    step(0, 0, 2'd0, 8'd0, 1, 1, 2'd0);
    total++;
    if (err_o !== ErrEn || occupancy_o !== 4'd0) begin
      bad++;
      $display("FAIL err_set got err=%b occ=%0d want err=%b occ=0",
               err_o, occupancy_o, ErrEn);
    end
    idle();
    total++;
    if (err_o !== ErrEn) begin
      bad++; $display("FAIL err_hold got=%b want=%b", err_o, ErrEn);
    end
    do_reset();
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("FAIL err_clear got=%b want=0", err_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 2'(i), 8'd10, 0, 0, 2'd0);
    total++;
    if (occupancy_o !== 4'd4) begin
      bad++; $display("FAIL mid_occ got=%0d want=4", occupancy_o);
    end
    do_reset();
    total++;
    if (occupancy_o !== 4'd0 || release_en_o !== 4'b0 || req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst got occ=%0d rel=%b rdy=%b want occ=0 rel=0000 rdy=1",
               occupancy_o, release_en_o, req_ready_o);
    end
    for (int i = 0; i < 12; i++) idle();
    total++;
    if (release_en_o !== 4'b0) begin
      bad++; $display("FAIL mid_norel got=%b want=0000", release_en_o);
    end
  endtask

  task automatic test_random();
    logic [3:0] er;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      step(($urandom % 300) == 0, $urandom % 2, 2'($urandom % 4),
           8'($urandom % 8), $urandom % 2, ($urandom % 4) != 0,
           2'($urandom % 4));
      er = exp_rel();
      total++;
      if (release_en_o !== er || occupancy_o !== 4'(m_id.size()) ||
          req_ready_o !== (m_id.size() < NS) || err_o !== m_err) begin
        bad++;
        $display("FAIL rand n=%0d got rel=%b occ=%0d rdy=%b err=%b want rel=%b occ=%0d rdy=%b err=%b",
                 n, release_en_o, occupancy_o, req_ready_o, err_o,
                 er, m_id.size(), m_id.size() < NS, m_err);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_id_i = '0;
    req_delay_i = '0;
    rsp_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    rsp_id_i = '0;
    m_err = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_single();
    test_in_order();
    test_full();
    test_zero_delay();
    test_error();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simmem_release_scheduler.md
SIMMEM_RELEASE_SCHEDULER -- requirements
Module: simmem_release_scheduler

Interface
REQ-001 The block SHALL have parameter IDWidth, default 2, meaning width of the transaction identifier.
REQ-002 The block SHALL have parameter NbSlots, default 8, meaning the number of outstanding delay slots.
REQ-003 The block SHALL have parameter DelayWidth, default 8, meaning the width of the per-request delay in cycles.
REQ-004 clk_i  input  1  system clock; all logic on the rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 req_valid_i  input  1  new delayed request offered.
REQ-007 req_ready_o  output  1  a free slot is available.
REQ-008 req_id_i  input  IDWidth  identifier of the offered request.
REQ-009 req_delay_i  input  DelayWidth  cycles to wait before release.
REQ-010 release_en_o  output  2**IDWidth  per-ID release enable, to the linked-list bank.
REQ-011 rsp_valid_i  input  1  bank output valid, observed.
REQ-012 rsp_ready_i  input  1  downstream ready at bank output, observed.
REQ-013 rsp_id_i  input  IDWidth  identifier of the bank output beat.
REQ-014 occupancy_o  output  $clog2(NbSlots)+1  count of non-FREE slots.
REQ-015 err_o  output  1  sticky protocol error flag.

Function
REQ-016 Each slot SHALL hold a state from {FREE, COUNTING, EXPIRED}, an ID, and a DelayWidth-bit down-counter.
REQ-017 req_ready_o SHALL be 1 iff at least one slot is FREE at the start of the cycle; a slot freed in the same cycle SHALL NOT be reused until the next cycle.
REQ-018 On req_valid_i && req_ready_o, the lowest-index FREE slot SHALL load the ID and delay and enter COUNTING, or EXPIRED directly if req_delay_i == 0.
REQ-019 A COUNTING slot SHALL decrement its counter once per cycle and move to EXPIRED on the edge at which its counter goes from 1 to 0.
REQ-020 A request with delay D>0 accepted at edge N SHALL be EXPIRED after edge N+D; a request with D==0 SHALL be EXPIRED after edge N.
REQ-021 The block SHALL track per-slot age with an NbSlots x NbSlots age matrix updated on allocation, so the oldest slot per ID is known.
REQ-022 release_en_o[k] SHALL be 1, combinationally from registered state, iff the oldest non-FREE slot with ID k is EXPIRED; younger EXPIRED slots of the same ID SHALL NOT assert it.
REQ-023 On rsp_valid_i && rsp_ready_i, the oldest non-FREE slot with ID rsp_id_i SHALL return to FREE on that edge.
REQ-024 Allocation and free in the same cycle SHALL both take effect, and occupancy_o SHALL stay unchanged.
REQ-025 A handshake whose rsp_id_i has no EXPIRED oldest slot is a protocol error; the slot state SHALL NOT change for it.
REQ-026 occupancy_o SHALL never exceed NbSlots, and counters SHALL NOT wrap below 0.

Reset
REQ-027 While rst_i is 1 at a rising edge, all slots SHALL become FREE, the counters and age matrix SHALL clear, and err_o SHALL clear.
REQ-028 During and after reset, the outputs SHALL be: req_ready_o=1, release_en_o=0, occupancy_o=0, err_o=0.
REQ-029 Reset asserted mid-operation SHALL discard all outstanding slots without any release_en_o pulse.

Configuration
REQ-030 With macro SIMMEM_RELEASE_SCHEDULER_ERR_EN defined, err_o SHALL set on the cycle after a REQ-025 error and hold until reset.
REQ-031 Without SIMMEM_RELEASE_SCHEDULER_ERR_EN, err_o SHALL be tied to 0 and no error-detection logic SHALL be built; REQ-025 slot behaviour is unchanged.

Verification
REQ-032 Single request: id=1, delay=3 accepted at edge 0 -> release_en_o=4'b0010 from after edge 3; rsp handshake id=1 at edge 5 -> release_en_o=0, occupancy_o=0.
REQ-033 In-order per ID: id=2 delay=5 at edge 0, then id=2 delay=1 at edge 1 -> release_en_o[2]=0 until after edge 5, despite the younger slot being EXPIRED at edge 2.
REQ-034 Full: 8 requests with delay=20 -> req_ready_o=0 and occupancy_o=8; a 9th req_valid_i is not accepted; simultaneous free and new request at full -> the new request is accepted only on the following cycle.
REQ-035 Zero delay: id=3, delay=0 at edge 0 -> release_en_o[3]=1 after edge 0.
REQ-036 Error: rsp handshake id=0 with no slot of ID 0 -> with ERR_EN, err_o=1 from the next cycle until rst_i; without ERR_EN, err_o=0.
REQ-037 Reset mid-run: 4 COUNTING slots, rst_i=1 for one edge -> occupancy_o=0, release_en_o=0, req_ready_o=1.
